// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time, holds the word for decode.
// Define INSTRUCTION_FETCH_ALIGNMENT_CHECK_EN to trap on misaligned fetch addresses.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        memory_request_valid,
    output logic [31:0] memory_request_address,
    input  logic        memory_request_ready,
    input  logic        memory_response_valid,
    input  logic [31:0] memory_response_data,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] program_counter_of_instruction,
    input  logic        instruction_ready,
    output logic [31:0] fetch_count,
    output logic        error,
    output logic [31:0] error_address
);

    typedef enum logic [2:0] {
        StStart,
        StFetchRequest,
        StFetchWait,
        StInstructionHold,
        StAwaitNextPc,
        StTrapped
    } state_e;

    state_e state;

`ifdef INSTRUCTION_FETCH_ALIGNMENT_CHECK_EN
    logic        error_q;
    logic [31:0] error_address_q;

    assign error         = error_q;
    assign error_address = error_address_q;
`else
    assign error         = 1'b0;
    assign error_address = 32'h0000_0000;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                          <= StStart;
            memory_request_valid           <= 1'b0;
            memory_request_address         <= RESET_VECTOR;
            instruction_valid              <= 1'b0;
            instruction                    <= 32'h0000_0000;
            program_counter_of_instruction <= RESET_VECTOR;
            fetch_count                    <= 32'h0000_0000;
`ifdef INSTRUCTION_FETCH_ALIGNMENT_CHECK_EN
            error_q                        <= 1'b0;
            error_address_q                <= 32'h0000_0000;
`endif
        end else begin
            case (state)
                StStart: begin
`ifdef INSTRUCTION_FETCH_ALIGNMENT_CHECK_EN
                    if (RESET_VECTOR[1:0] != 2'b00) begin
                        error_q         <= 1'b1;
                        error_address_q <= RESET_VECTOR;
                        state           <= StTrapped;
                    end else
`endif
                    begin
                        memory_request_address <= RESET_VECTOR;
                        memory_request_valid   <= 1'b1;
                        state                  <= StFetchRequest;
                    end
                end
                StFetchRequest: begin
                    // Address stays put until the handshake completes.
                    if (memory_request_ready) begin
                        memory_request_valid <= 1'b0;
                        state                <= StFetchWait;
                    end
                end
                StFetchWait: begin
                    if (memory_response_valid) begin
                        instruction                    <= memory_response_data;
                        program_counter_of_instruction <= memory_request_address;
                        instruction_valid              <= 1'b1;
                        state                          <= StInstructionHold;
                    end
                end
                StInstructionHold: begin
                    if (instruction_ready) begin
                        instruction_valid <= 1'b0;
                        fetch_count       <= fetch_count + 32'd1;
                        state             <= StAwaitNextPc;
                    end
                end
                StAwaitNextPc: begin
                    if (next_pc_valid) begin
`ifdef INSTRUCTION_FETCH_ALIGNMENT_CHECK_EN
                        if (next_pc[1:0] != 2'b00) begin
                            error_q         <= 1'b1;
                            error_address_q <= next_pc;
                            state           <= StTrapped;
                        end else begin
                            memory_request_address <= next_pc;
                            memory_request_valid   <= 1'b1;
                            state                  <= StFetchRequest;
                        end
`else
                        // Low bits dropped: fetch continues at the word-aligned address.
                        memory_request_address <= next_pc & 32'hFFFF_FFFC;
                        memory_request_valid   <= 1'b1;
                        state                  <= StFetchRequest;
`endif
                    end
                end
                StTrapped: begin
                    state <= StTrapped;
                end
                default: begin
                    state <= StStart;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes expected requests and
// instructions into queues; a negedge monitor pops and compares on each handshake/capture.
module tb_instruction_fetch;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        memory_request_valid;
    logic [31:0] memory_request_address;
    logic        memory_request_ready;
    logic        memory_response_valid;
    logic [31:0] memory_response_data;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] program_counter_of_instruction;
    logic        instruction_ready;
    logic [31:0] fetch_count;
    logic        error;
    logic [31:0] error_address;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_pc_q[$];

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_VECTOR(RV)
    ) dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .next_pc_valid                  (next_pc_valid),
        .next_pc                        (next_pc),
        .memory_request_valid           (memory_request_valid),
        .memory_request_address         (memory_request_address),
        .memory_request_ready           (memory_request_ready),
        .memory_response_valid          (memory_response_valid),
        .memory_response_data           (memory_response_data),
        .instruction_valid              (instruction_valid),
        .instruction                    (instruction),
        .program_counter_of_instruction (program_counter_of_instruction),
        .instruction_ready              (instruction_ready),
        .fetch_count                    (fetch_count),
        .error                          (error),
        .error_address                  (error_address)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        logic        seen;
        logic [31:0] held_data;
        logic [31:0] held_pc;
        logic [31:0] e;
        seen = 1'b0;
        held_data = '0;
        held_pc = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                seen = 1'b0;
            end else begin
                if (memory_request_valid && memory_request_ready) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_request: got address %h expected none",
                                 memory_request_address);
                    end else begin
                        e = exp_req_q.pop_front();
                        check("request_address", memory_request_address, e);
                    end
                end
                if (instruction_valid && !seen) begin
                    seen = 1'b1;
                    if (exp_data_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instruction: got %h expected none", instruction);
                    end else begin
                        held_data = exp_data_q.pop_front();
                        held_pc   = exp_pc_q.pop_front();
                        check("instruction", instruction, held_data);
                        check("instruction_pc", program_counter_of_instruction, held_pc);
                    end
                end else if (instruction_valid) begin
                    check("held_instruction", instruction, held_data);
                    check("held_pc", program_counter_of_instruction, held_pc);
                end else begin
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset_n               = 1'b0;
        next_pc_valid         = 1'b0;
        next_pc               = '0;
        memory_request_ready  = 1'b0;
        memory_response_valid = 1'b0;
        memory_response_data  = '0;
        instruction_ready     = 1'b0;
        repeat (2) tick;

        check("rst_req_valid", {31'b0, memory_request_valid}, 32'd0);
        check("rst_req_addr", memory_request_address, RV);
        check("rst_instr_valid", {31'b0, instruction_valid}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc", program_counter_of_instruction, RV);
        check("rst_count", fetch_count, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_error_addr", error_address, 32'd0);

        // First fetch: ready=1, response the cycle after acceptance.
        exp_req_q.push_back(RV);
        exp_data_q.push_back(32'h0000_0013);
        exp_pc_q.push_back(RV);
        memory_request_ready = 1'b1;
        reset_n = 1'b1;
        tick;
        check("first_req_valid", {31'b0, memory_request_valid}, 32'd1);
        check("first_req_addr", memory_request_address, RV);
        tick;
        check("req_drop_after_accept", {31'b0, memory_request_valid}, 32'd0);
        memory_response_valid = 1'b1;
        memory_response_data  = 32'h0000_0013;
        tick;
        memory_response_valid = 1'b0;
        memory_response_data  = '0;
        check("instr_valid_edge3", {31'b0, instruction_valid}, 32'd1);
        check("instr_edge3", instruction, 32'h0000_0013);
        check("pc_edge3", program_counter_of_instruction, RV);

        // Decode stalls 5 cycles; next_pc_valid during hold must be ignored.
        next_pc_valid = 1'b1;
        next_pc       = 32'h0000_0500;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_valid", {31'b0, instruction_valid}, 32'd1);
            check("hold_count", fetch_count, 32'd0);
            check("hold_no_request", {31'b0, memory_request_valid}, 32'd0);
        end
        next_pc_valid     = 1'b0;
        instruction_ready = 1'b1;
        tick;
        check("count_after_accept", fetch_count, 32'd1);
        check("valid_after_accept", {31'b0, instruction_valid}, 32'd0);

        // Spurious response and stray instruction_ready while awaiting next PC.
        memory_response_valid = 1'b1;
        memory_response_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("await_instr", instruction, 32'h0000_0013);
            check("await_pc", program_counter_of_instruction, RV);
            check("await_valid", {31'b0, instruction_valid}, 32'd0);
            check("await_no_request", {31'b0, memory_request_valid}, 32'd0);
            check("await_count", fetch_count, 32'd1);
        end
        memory_response_valid = 1'b0;
        instruction_ready     = 1'b0;

        // Next PC 0x200 with memory stalling 4 cycles.
        memory_request_ready = 1'b0;
        next_pc_valid        = 1'b1;
        next_pc              = 32'h0000_0200;
        exp_req_q.push_back(32'h0000_0200);
        tick;
        next_pc_valid = 1'b0;
        check("stall_req_valid", {31'b0, memory_request_valid}, 32'd1);
        check("stall_req_addr", memory_request_address, 32'h0000_0200);
        memory_response_valid = 1'b1;
        memory_response_data  = 32'hBAD0_0BAD;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("stall_valid_stable", {31'b0, memory_request_valid}, 32'd1);
            check("stall_addr_stable", memory_request_address, 32'h0000_0200);
        end
        memory_request_ready = 1'b1;
        tick;
        // Response seen in the acceptance cycle must not be captured.
        memory_request_ready  = 1'b0;
        memory_response_valid = 1'b0;
        check("accept_drop_valid", {31'b0, memory_request_valid}, 32'd0);
        check("same_cycle_resp_ignored", {31'b0, instruction_valid}, 32'd0);
        tick;
        check("wait_no_instr", {31'b0, instruction_valid}, 32'd0);
        exp_data_q.push_back(32'h00A0_0093);
        exp_pc_q.push_back(32'h0000_0200);
        memory_response_valid = 1'b1;
        memory_response_data  = 32'h00A0_0093;
        tick;
        memory_response_valid = 1'b0;
        check("second_instr_valid", {31'b0, instruction_valid}, 32'd1);
        instruction_ready = 1'b1;
        tick;
        instruction_ready = 1'b0;
        check("count_two", fetch_count, 32'd2);

        // Misaligned next PC.
        next_pc_valid = 1'b1;
        next_pc       = 32'h0000_0206;
`ifdef INSTRUCTION_FETCH_ALIGNMENT_CHECK_EN
        tick;
        next_pc_valid = 1'b0;
        check("trap_error", {31'b0, error}, 32'd1);
        check("trap_error_addr", error_address, 32'h0000_0206);
        check("trap_no_request", {31'b0, memory_request_valid}, 32'd0);
        memory_request_ready = 1'b1;
        repeat (4) tick;
        check("trapped_no_request", {31'b0, memory_request_valid}, 32'd0);
        check("trapped_no_instr", {31'b0, instruction_valid}, 32'd0);
        check("trapped_error_sticky", {31'b0, error}, 32'd1);
        memory_request_ready = 1'b0;
`else
        exp_req_q.push_back(32'h0000_0204);
        tick;
        next_pc_valid = 1'b0;
        check("aligned_req_valid", {31'b0, memory_request_valid}, 32'd1);
        check("aligned_req_addr", memory_request_address, 32'h0000_0204);
        check("no_error", {31'b0, error}, 32'd0);
        check("no_error_addr", error_address, 32'd0);
        memory_request_ready = 1'b1;
        tick;
        memory_request_ready = 1'b0;
        check("aligned_accept_drop", {31'b0, memory_request_valid}, 32'd0);
`endif

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_instr_valid", {31'b0, instruction_valid}, 32'd0);
        check("async_rst_req_valid", {31'b0, memory_request_valid}, 32'd0);
        check("async_rst_req_addr", memory_request_address, RV);
        check("async_rst_pc", program_counter_of_instruction, RV);
        check("async_rst_instr", instruction, 32'd0);
        check("async_rst_count", fetch_count, 32'd0);
        check("async_rst_error", {31'b0, error}, 32'd0);
        check("async_rst_error_addr", error_address, 32'd0);
        repeat (2) tick;

        // Normal fetch from the reset vector again.
        exp_req_q.push_back(RV);
        exp_data_q.push_back(32'h0000_0297);
        exp_pc_q.push_back(RV);
        memory_request_ready = 1'b1;
        reset_n = 1'b1;
        tick;
        check("refetch_req_valid", {31'b0, memory_request_valid}, 32'd1);
        tick;
        memory_request_ready  = 1'b0;
        memory_response_valid = 1'b1;
        memory_response_data  = 32'h0000_0297;
        tick;
        memory_response_valid = 1'b0;
        check("refetch_instr_valid", {31'b0, instruction_valid}, 32'd1);
        check("refetch_instr", instruction, 32'h0000_0297);
        tick;

        check("pending_requests", 32'(exp_req_q.size()), 32'd0);
        check("pending_instructions", 32'(exp_data_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
